// File: rtl/clock_monitor.sv
// Measures half/full periods of an asynchronous monitored clock in system-clock cycles,
// tracks lock against an expected half period, and flags range and stuck errors.
module clock_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 10,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clr_err,
  output logic [CNT_W-1:0] half_cnt,
  output logic             half_valid,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_range,
  output logic             err_stuck
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACQ   = 3'd1;
  localparam logic [2:0] MEAS  = 3'd2;
  localparam logic [2:0] LOCK  = 3'd3;
  localparam logic [2:0] STUCK = 3'd4;

  localparam int              LC_W    = $clog2(LOCK_N + 1);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOCK_N);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] LO      = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);

  // sync[0]=s1, sync[1]=s2, sync[2]=s3 history
  logic [2:0]       sync;
  logic [2:0]       st, st_n;
  logic [CNT_W-1:0] run, hi_len;
  logic [LC_W-1:0]  lc, lc_inc;
  logic             hi_ok;
  logic             tgl, rise, in_rng, meas, stuck_hit, set_r, set_s;

  assign tgl    = sync[1] ^ sync[2];
  assign rise   = sync[1] & ~sync[2];
  assign in_rng = (run >= LO) && (run <= HI);
  assign lc_inc = (lc == LC_MAX) ? lc : lc + LC_W'(1);
  assign set_r  = meas & ~in_rng;
  assign set_s  = stuck_hit;

  always_comb begin
    st_n      = st;
    meas      = 1'b0;
    stuck_hit = 1'b0;
    if (!enable) st_n = IDLE;
    else begin
      case (st)
        IDLE:       st_n = ACQ;
        ACQ, STUCK: if (tgl) st_n = MEAS;
        MEAS, LOCK: begin
          if (tgl) begin
            meas = 1'b1;
            if (!in_rng)              st_n = MEAS;
            else if (lc_inc == LC_MAX) st_n = LOCK;
          end else if (run == TO) begin
            // an edge on the timeout cycle is measured above, so it never lands here
            stuck_hit = 1'b1;
            st_n      = STUCK;
          end
        end
        default:    st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync         <= '0;
      st           <= IDLE;
      run          <= '0;
      lc           <= '0;
      hi_len       <= '0;
      hi_ok        <= 1'b0;
      half_cnt     <= '0;
      half_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_range    <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      sync         <= {sync[1:0], mon_clk};
      st           <= st_n;
      half_valid   <= 1'b0;
      period_valid <= 1'b0;
      err_range    <= set_r | (err_range & ~clr_err);
      err_stuck    <= set_s | (err_stuck & ~clr_err);

      if (!enable || st == IDLE) run <= '0;
      else if (tgl)              run <= CNT_W'(1);
      else if (run != RUN_MAX)   run <= run + CNT_W'(1);

      if (!enable || st == IDLE || stuck_hit || set_r) lc <= '0;
      else if (meas)                                   lc <= lc_inc;

      if (!enable || stuck_hit || set_r)           locked <= 1'b0;
      else if (meas && in_rng && lc_inc == LC_MAX) locked <= 1'b1;

      if (meas) begin
        half_cnt   <= run;
        half_valid <= 1'b1;
      end

      // a period is only reported once a full high half has been seen since (re)acquire
      if (!enable || st == IDLE || st == ACQ || st == STUCK || stuck_hit) hi_ok <= 1'b0;
      else if (meas && !rise) begin
        hi_len <= run;
        hi_ok  <= 1'b1;
      end else if (meas && rise && hi_ok) begin
        period       <= {1'b0, hi_len} + {1'b0, run};
        period_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: an event-level model of edge timing and lock rules
// checked every cycle, plus literal expectations at the end of each scenario.
module tb_clock_monitor;
  localparam int CNT_W = 8, EXP_HALF = 10, TOL = 1, LOCK_N = 4, TIMEOUT = 64;
  localparam int S_IDLE = 0, S_ACQ = 1, S_MEAS = 2, S_LOCK = 3, S_STUCK = 4;
  localparam int NT = 8192;

  logic clock = 0, reset = 1, mon_clk = 0, enable = 0, clr_err = 0;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W:0]   period;
  logic half_valid, period_valid, locked, err_range, err_stuck;

  clock_monitor #(.CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_N(LOCK_N),
                  .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .mon_clk(mon_clk), .enable(enable), .clr_err(clr_err),
    .half_cnt(half_cnt), .half_valid(half_valid), .period(period),
    .period_valid(period_valid), .locked(locked), .err_range(err_range),
    .err_stuck(err_stuck));

  always #5 clock = ~clock;

  int errors = 0, checks = 0, cyc = 0;
  // tog[k]: mon_clk changed just before posedge k (1 = went high, 2 = went low)
  int tog [0:NT-1];

  // model state, in terms of edge times rather than counters
  int m_st = S_IDLE, m_last = 0, m_lc = 0, m_hi = 0, m_hcnt = 0, m_per = 0;
  bit m_hiok = 0, m_hv = 0, m_pv = 0, m_lk = 0, m_er = 0, m_es = 0;

  task automatic model_step();
    int ev, d;
    bit sr, ss;
    cyc++;
    if (reset) begin
      m_st = S_IDLE; m_last = 0; m_lc = 0; m_hi = 0; m_hcnt = 0; m_per = 0;
      m_hiok = 0; m_hv = 0; m_pv = 0; m_lk = 0; m_er = 0; m_es = 0;
      return;
    end
    // a level first sampled at edge k is acted on at edge k+2
    ev = (cyc >= 2 && cyc - 2 < NT) ? tog[cyc-2] : 0;
    sr = 0; ss = 0; m_hv = 0; m_pv = 0;
    if (!enable) begin
      m_st = S_IDLE; m_lk = 0; m_lc = 0; m_hiok = 0;
    end else if (m_st == S_IDLE) begin
      m_st = S_ACQ; m_hiok = 0; m_lc = 0;
    end else if (m_st == S_ACQ || m_st == S_STUCK) begin
      m_hiok = 0;
      if (ev != 0) begin m_last = cyc; m_st = S_MEAS; end
    end else if (ev != 0) begin
      d = cyc - m_last;
      m_last = cyc;
      m_hcnt = d; m_hv = 1;
      if (ev == 2) begin m_hi = d; m_hiok = 1; end
      else if (m_hiok) begin m_per = m_hi + d; m_pv = 1; end
      if (d >= EXP_HALF - TOL && d <= EXP_HALF + TOL) begin
        if (m_lc < LOCK_N) m_lc++;
        if (m_lc == LOCK_N) begin m_lk = 1; m_st = S_LOCK; end
      end else begin
        sr = 1; m_lc = 0; m_lk = 0; m_st = S_MEAS;
      end
    end else if (cyc - m_last == TIMEOUT) begin
      ss = 1; m_lk = 0; m_lc = 0; m_hiok = 0; m_st = S_STUCK;
    end
    m_er = sr | (m_er & ~clr_err);
    m_es = ss | (m_es & ~clr_err);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic cmp_all();
    int eh, ep;
    bit ehv, epv, elk, eer, ees;
    if (reset) begin eh = 0; ep = 0; ehv = 0; epv = 0; elk = 0; eer = 0; ees = 0; end
    else begin eh = m_hcnt; ep = m_per; ehv = m_hv; epv = m_pv; elk = m_lk; eer = m_er; ees = m_es; end
    checks++;
    if (int'(half_cnt) != eh || half_valid != ehv || int'(period) != ep || period_valid != epv ||
        locked != elk || err_range != eer || err_stuck != ees) begin
      errors++;
      $display("FAIL cycle %0d outputs: got hc=%0d hv=%0b per=%0d pv=%0b lk=%0b er=%0b es=%0b want hc=%0d hv=%0b per=%0d pv=%0b lk=%0b er=%0b es=%0b",
               cyc, half_cnt, half_valid, period, period_valid, locked, err_range, err_stuck,
               eh, ehv, ep, epv, elk, eer, ees);
    end
  endtask

  initial forever begin
    @(negedge clock);
    cmp_all();
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // set mon_clk at a negedge, then hold it for n cycles
  task automatic drive(input logic v, input int n);
    if (v !== mon_clk && cyc + 1 < NT) tog[cyc+1] = v ? 1 : 2;
    mon_clk = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic clr_pulse();
    clr_err = 1;
    @(negedge clock);
    clr_err = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset half_cnt", half_cnt, 0);
    chk("reset locked", locked, 0);
    chk("reset errs", {err_range, err_stuck}, 0);
    reset = 0;
    @(negedge clock);

    // nominal 10-cycle halves: lock on the 4th measured half
    enable = 1;
    drive(1, 10);
    for (int j = 1; j <= 10; j++) begin
      drive(~mon_clk, 10);
      if (j == 3) chk("no lock after 3 halves", locked, 0);
      if (j == 4) chk("lock on 4th half", locked, 1);
    end
    chk("nominal half_cnt", half_cnt, 10);
    chk("nominal period", period, 20);
    chk("nominal errs", {err_range, err_stuck}, 0);

    // one stretched half while locked
    drive(~mon_clk, 13);
    drive(~mon_clk, 10);
    chk("stretch err_range", err_range, 1);
    chk("stretch unlock", locked, 0);
    chk("stretch half_cnt", half_cnt, 13);
    repeat (3) drive(~mon_clk, 10);
    chk("relock pending", locked, 0);
    drive(~mon_clk, 10);
    chk("relock", locked, 1);
    chk("err_range sticky", err_range, 1);

    // stuck low
    if (mon_clk) drive(0, 80);
    else begin drive(1, 10); drive(0, 80); end
    chk("stuck flag", err_stuck, 1);
    chk("stuck unlock", locked, 0);
    drive(1, 10);
    drive(0, 10);
    chk("restart half_cnt", half_cnt, 10);
    drive(1, 10);

    // clear flags, then alternating 9/11 halves
    clr_pulse();
    chk("clr both", {err_range, err_stuck}, 0);
    for (int i = 0; i < 10; i++) drive(~mon_clk, (i % 2) ? 11 : 9);
    chk("alt no err", err_range, 0);
    chk("alt locked", locked, 1);
    chk("alt period", period, 20);
    drive(~mon_clk, 8);
    drive(~mon_clk, 10);
    chk("half 8 err", err_range, 1);
    chk("half 8 half_cnt", half_cnt, 8);

    // clear coincident with an out-of-range half: set wins
    clr_pulse();
    chk("clr range", err_range, 0);
    repeat (3) drive(~mon_clk, 10);
    drive(~mon_clk, 12);
    drive(~mon_clk, 2);
    clr_pulse();
    repeat (7) @(negedge clock);
    chk("set beats clr", err_range, 1);
    chk("set beats clr half", half_cnt, 12);
    clr_pulse();
    chk("clr alone", {err_range, err_stuck}, 0);

    // edge exactly at TIMEOUT is measured, not stuck
    drive(~mon_clk, 10);
    drive(~mon_clk, 64);
    drive(~mon_clk, 10);
    chk("timeout edge half", half_cnt, 64);
    chk("timeout edge not stuck", err_stuck, 0);
    chk("timeout edge range", err_range, 1);

    // toggle every system cycle
    repeat (6) drive(~mon_clk, 1);
    repeat (5) @(negedge clock);
    chk("fast toggle half", half_cnt, 1);

    // disable mid-measurement
    repeat (6) drive(~mon_clk, 10);
    chk("pre-disable lock", locked, 1);
    drive(~mon_clk, 4);
    enable = 0;
    repeat (6) @(negedge clock);
    chk("disable unlock", locked, 0);
    chk("disable hold half", half_cnt, 10);
    repeat (2) drive(~mon_clk, 7);
    chk("idle no measure", half_cnt, 10);

    // re-enable, lock, then asynchronous reset mid-half
    enable = 1;
    repeat (7) drive(~mon_clk, 10);
    chk("re-lock", locked, 1);
    drive(~mon_clk, 0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2 reset = 1;
    #1;
    chk("async reset half_cnt", half_cnt, 0);
    chk("async reset period", period, 0);
    chk("async reset flags", {half_valid, period_valid, locked, err_range, err_stuck}, 0);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
